picosoc_irq_ctrl: RTL
=====================

// Module: picosoc_irq_ctrl
// PURPOSE
//  Parametrised interrupt controller between external interrupt pins and the picosoc CPU IRQ vector.
//  Supersedes the fixed irq_5/irq_6/irq_7 pin hookup:
//   - N channels, each with a synchroniser.
//   - Per-channel edge/level mode and polarity.
//   - Pending, enable and software-set registers on the iomem bus.
//  Sits on the iomem bus beside the UART and LED peripherals; irq_out feeds the CPU irq vector.
// PARAMETERS
//  NUM_IRQ      3             number of interrupt channels, 1..32
//  SYNC_STAGES  2             synchroniser flops per input, 2..4
//  BASE_ADDR    32'h0300_0000 register window base; window is 32 bytes
// PORTS
//  clk_50m      in   1        system clock, 50 MHz
//  resetn       in   1        asynchronous, active-low reset
//  irq_in       in   NUM_IRQ  raw external interrupt pins, asynchronous
//  iomem_valid  in   1        bus request
//  iomem_ready  out  1        bus acknowledge, one-cycle pulse
//  iomem_wstrb  in   4        byte write strobes; 4'b0000 means read
//  iomem_addr   in   32       byte address
//  iomem_wdata  in   32       write data
//  iomem_rdata  out  32       read data, valid while iomem_ready=1
//  irq_out      out  NUM_IRQ  pending & enable, registered, to CPU
//  irq_any      out  1        OR-reduction of irq_out, registered
// BEHAVIOUR
//  Reset values: all outputs 0; PENDING=0, ENABLE=0, MODE=0 (level), POLARITY=all 1 (active-low).
//   Synchroniser flops reset to 1 (idle-high pins).
//  active[i] = sync[i] ^ POLARITY[i].
//  Register map (offset from BASE_ADDR):
//   0x00 PENDING  R / W1C
//   0x04 ENABLE   RW
//   0x08 MODE     RW, 1=edge 0=level
//   0x0C POLARITY RW, 1=active-low
//   0x10 RAW      R, active vector
//   0x14 SWSET    W, write 1 sets PENDING, reads 0
//   0x18..0x1C    reserved: read 0, writes ignored
//  Register width rules:
//   - Bits >= NUM_IRQ read 0 and ignore writes.
//   - wstrb byte lanes are honoured per byte.
//  Edge mode:
//   - PENDING[i] sets on the 0->1 transition of active[i], detected against a 1-cycle delayed copy.
//   - W1C clears the bit.
//   - Simultaneous edge and W1C in the same cycle: set wins.
//  Level mode:
//   - PENDING[i] <= active[i] | swset_hold[i]; W1C is ineffective while active stays 1.
//   - SWSET in level mode holds the bit until it is cleared by W1C.
//  SWSET and W1C to the same bit in the same cycle: set wins.
//  MODE change from edge to level does not clear PENDING; the next cycle follows the level rule.
//  Latency:
//   - Pin edge to PENDING: SYNC_STAGES+1 cycles.
//   - PENDING to irq_out/irq_any: 1 cycle.
//   - ENABLE write to irq_out: 1 cycle after the iomem_ready cycle.
//  Bus handshake:
//   - FSM states IDLE -> ACK -> IDLE.
//   - IDLE: iomem_valid with addr in [BASE_ADDR, BASE_ADDR+0x1F] -> ACK.
//   - ACK: iomem_ready=1 for exactly one cycle; the write is committed in this cycle; rdata is driven.
//   - Next state is IDLE regardless of iomem_valid, so a back-to-back request gets a fresh ACK 2 cycles later.
//   - Addresses outside the window: never ready, rdata=0.
//  Outside ACK, iomem_rdata = 0.
//  Reset mid-transaction: immediately returns to IDLE with iomem_ready=0; no partial write is retained.
// STRUCTURE
//  Shared package picosoc_irq_pkg:
//   - Register offset localparams (OFS_PENDING..OFS_SWSET).
//   - Bus FSM state encoding.
//   - Reset value constants.
//  Sub-module irq_sync_edge (one instance per channel):
//   - SYNC_STAGES synchroniser with reset value 1.
//   - Polarity XOR.
//   - Delayed copy and rise pulse output.
//  Top level: generate loop of irq_sync_edge, register file, bus FSM, output registers.
// TESTING
//  1 Reset, NUM_IRQ=3: read 0x00/0x04/0x08/0x0C
//    -> 0, 0, 0, 0x7; irq_out=0, irq_any=0.
//  2 Edge mode: MODE=0x1, ENABLE=0x1, pulse irq_in[0] low 1 cycle
//    -> PENDING=0x1 after SYNC_STAGES+1 cycles; irq_out[0]=1 one cycle later.
//    Write 0x00=0x1 -> irq_out[0]=0.
//  3 Level mode ch1: hold irq_in[1]=0, ENABLE=0x2, W1C 0x2 -> PENDING stays 0x2.
//    Release pin -> PENDING=0 after SYNC_STAGES+1 cycles.
//  4 Collision: edge on ch2 lands in the same cycle as W1C of bit 2 -> PENDING[2]=1.
//    SWSET=0x4 plus W1C=0x4 in the same cycle -> bit stays set.
//  5 Bus:
//    - Read at BASE_ADDR+0x40 -> no iomem_ready for 10 cycles.
//    - Write wstrb=4'b0010 to ENABLE with data 0xFFFF_FFFF -> ENABLE unchanged (bits >= 3 are 0, byte 0 not strobed).
//    - Write 0xFFFF_FFFF, wstrb=4'hF -> readback 0x7.
//  6 Assert resetn=0 during the ACK cycle of a write of ENABLE=0x7
//    -> iomem_ready=0 immediately; ENABLE reads 0 after reset.

Source files
------------

// File: rtl/picosoc_irq_pkg.sv
// ----------------------------------------------------------------------------
// picosoc_irq_pkg
//   Shared definitions for the picosoc interrupt controller:
//   - register offsets inside the 32-byte iomem window
//   - bus handshake FSM state encoding
//   - reset values of the software-visible registers and synchroniser flops
//   - small helper functions for channel and byte-lane masks
// ----------------------------------------------------------------------------
package picosoc_irq_pkg;

    // Register offsets, word aligned, relative to BASE_ADDR.
    localparam logic [4:0] OFS_PENDING  = 5'h00;
    localparam logic [4:0] OFS_ENABLE   = 5'h04;
    localparam logic [4:0] OFS_MODE     = 5'h08;
    localparam logic [4:0] OFS_POLARITY = 5'h0C;
    localparam logic [4:0] OFS_RAW      = 5'h10;
    localparam logic [4:0] OFS_SWSET    = 5'h14;

    // Size of the decoded register window in bytes.
    localparam logic [31:0] WINDOW_SPAN = 32'h0000_0020;

    // Bus handshake: one ACK cycle per accepted request.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } bus_state_e;

    // Register reset values (masked to NUM_IRQ bits at the point of use).
    localparam logic [31:0] RST_PENDING  = 32'h0000_0000;
    localparam logic [31:0] RST_ENABLE   = 32'h0000_0000;
    localparam logic [31:0] RST_MODE     = 32'h0000_0000;   // level mode
    localparam logic [31:0] RST_POLARITY = 32'hFFFF_FFFF;   // active-low pins

    // Synchroniser flops start at the idle-high pin level.
    localparam logic SYNC_RST_LEVEL = 1'b1;

    // Mask with the low n bits set; n = 32 yields all ones.
    function automatic logic [31:0] irq_mask(input int unsigned n);
        logic [32:0] one_hot;
        one_hot = 33'd1 << n;
        return 32'(one_hot - 33'd1);
    endfunction

    // Expand the four byte strobes into a 32-bit bit mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] wstrb);
        return {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// ----------------------------------------------------------------------------
// irq_sync_edge
//   One interrupt channel front end: brings an asynchronous pin into the
//   clk_50m domain, applies the channel polarity and produces a one-cycle
//   rise pulse on each 0->1 transition of the resulting active level.
//
//   Ports
//     clk_50m   in   system clock
//     resetn    in   asynchronous active-low reset
//     irq_pin   in   raw asynchronous interrupt pin
//     polarity  in   1 = pin is active-low
//     active    out  synchronised, polarity-corrected level
//     rise      out  single-cycle pulse when active goes 0->1
// ----------------------------------------------------------------------------
module irq_sync_edge
    import picosoc_irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_50m,
    input  logic resetn,
    input  logic irq_pin,
    input  logic polarity,
    output logic active,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   active_d;

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge value of its neighbours; blocking here would collapse the chain.
    always_ff @(posedge clk_50m or negedge resetn) begin
        if (!resetn) begin
            sync_q   <= {SYNC_STAGES{SYNC_RST_LEVEL}};
            active_d <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], irq_pin};
            active_d <= active;
        end
    end

    // active_d resets to 0, which matches an idle-high pin with the default
    // active-low polarity, so no spurious rise appears after reset.
    assign active = sync_q[SYNC_STAGES-1] ^ polarity;
    assign rise   = active & ~active_d;

endmodule

// File: rtl/picosoc_irq_ctrl.sv
// ----------------------------------------------------------------------------
// picosoc_irq_ctrl
//   Parametrised interrupt controller between external interrupt pins and
//   the picosoc CPU irq vector. Each channel has a synchroniser, selectable
//   edge/level mode and polarity. PENDING / ENABLE / MODE / POLARITY / RAW /
//   SWSET registers sit in a 32-byte window on the iomem bus.
//
//   Ports
//     clk_50m      in   system clock, 50 MHz
//     resetn       in   asynchronous active-low reset
//     irq_in       in   raw external interrupt pins (asynchronous)
//     iomem_valid  in   bus request
//     iomem_ready  out  one-cycle bus acknowledge
//     iomem_wstrb  in   byte write strobes, 4'b0000 = read
//     iomem_addr   in   byte address
//     iomem_wdata  in   write data
//     iomem_rdata  out  read data, valid while iomem_ready = 1, else 0
//     irq_out      out  registered PENDING & ENABLE
//     irq_any      out  registered OR of PENDING & ENABLE
// ----------------------------------------------------------------------------
module picosoc_irq_ctrl
    import picosoc_irq_pkg::*;
#(
    parameter int          NUM_IRQ     = 3,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0300_0000
) (
    input  logic               clk_50m,
    input  logic               resetn,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               iomem_valid,
    output logic               iomem_ready,
    input  logic [3:0]         iomem_wstrb,
    input  logic [31:0]        iomem_addr,
    input  logic [31:0]        iomem_wdata,
    output logic [31:0]        iomem_rdata,
    output logic [NUM_IRQ-1:0] irq_out,
    output logic               irq_any
);

    // Bits at or above NUM_IRQ are held at zero by masking every update.
    localparam logic [31:0] IRQ_MASK = irq_mask(NUM_IRQ);

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [31:0] pending_q, enable_q, mode_q, polarity_q, swset_hold_q;
    logic [31:0] pending_d, enable_d, mode_d, polarity_d, swset_hold_d;

    // ------------------------------------------------------------------
    // Channel front ends
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] active_vec;
    logic [NUM_IRQ-1:0] rise_vec;
    logic [31:0]        active32;
    logic [31:0]        rise32;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_chan
        irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk_50m  (clk_50m),
            .resetn   (resetn),
            .irq_pin  (irq_in[i]),
            .polarity (polarity_q[i]),
            .active   (active_vec[i]),
            .rise     (rise_vec[i])
        );
    end

    assign active32 = 32'(active_vec);
    assign rise32   = 32'(rise_vec);

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    bus_state_e  state_q, state_d;
    logic        in_window;
    logic [4:0]  reg_sel;
    logic        wr_en;
    logic [31:0] wmask;
    logic [31:0] wbits;

    assign in_window = (iomem_addr >= BASE_ADDR) &&
                       ((iomem_addr - BASE_ADDR) < WINDOW_SPAN);
    assign reg_sel   = {iomem_addr[4:2], 2'b00};
    // Writes commit only in the ACK cycle, so an interrupted access never
    // leaves a partial update behind.
    assign wr_en     = (state_q == ST_ACK) && (iomem_wstrb != 4'b0000);
    assign wmask     = strb_mask(iomem_wstrb) & IRQ_MASK;
    assign wbits     = iomem_wdata & wmask;

    // ------------------------------------------------------------------
    // Bus handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50m or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal written in a combinational block gets a default at
    // the top, so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        iomem_ready = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (iomem_valid && in_window) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                // Always back to IDLE: a held request is acknowledged again
                // two cycles later rather than every cycle.
                iomem_ready = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // Read mux: driven only during ACK, zero otherwise.
    always_comb begin
        iomem_rdata = 32'h0000_0000;
        if (state_q == ST_ACK) begin
            case (reg_sel)
                OFS_PENDING:  iomem_rdata = pending_q;
                OFS_ENABLE:   iomem_rdata = enable_q;
                OFS_MODE:     iomem_rdata = mode_q;
                OFS_POLARITY: iomem_rdata = polarity_q;
                OFS_RAW:      iomem_rdata = active32;
                default:      iomem_rdata = 32'h0000_0000;  // SWSET, reserved
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register file next-state
    // ------------------------------------------------------------------
    logic [31:0] w1c_bits;
    logic [31:0] swset_bits;
    logic [31:0] edge_next;
    logic [31:0] level_next;

    always_comb begin
        enable_d   = enable_q;
        mode_d     = mode_q;
        polarity_d = polarity_q;
        w1c_bits   = 32'h0000_0000;
        swset_bits = 32'h0000_0000;

        if (wr_en) begin
            case (reg_sel)
                OFS_PENDING:  w1c_bits   = wbits;
                OFS_ENABLE:   enable_d   = (enable_q   & ~wmask) | wbits;
                OFS_MODE:     mode_d     = (mode_q     & ~wmask) | wbits;
                OFS_POLARITY: polarity_d = (polarity_q & ~wmask) | wbits;
                OFS_SWSET:    swset_bits = wbits;
                default:      ;  // RAW and reserved offsets ignore writes
            endcase
        end

        // Software-set latch: set wins over a simultaneous W1C.
        swset_hold_d = (swset_bits | (swset_hold_q & ~w1c_bits)) & IRQ_MASK;

        // Edge channels: sticky, cleared by W1C, any set source wins.
        edge_next  = rise32 | swset_bits | (pending_q & ~w1c_bits);
        // Level channels: follow the pin, plus any held software set.
        level_next = active32 | swset_hold_d;

        pending_d  = ((mode_q & edge_next) | (~mode_q & level_next)) & IRQ_MASK;
    end

    always_ff @(posedge clk_50m or negedge resetn) begin
        if (!resetn) begin
            pending_q    <= RST_PENDING  & IRQ_MASK;
            enable_q     <= RST_ENABLE   & IRQ_MASK;
            mode_q       <= RST_MODE     & IRQ_MASK;
            polarity_q   <= RST_POLARITY & IRQ_MASK;
            swset_hold_q <= 32'h0000_0000;
        end else begin
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            mode_q       <= mode_d;
            polarity_q   <= polarity_d;
            swset_hold_q <= swset_hold_d;
        end
    end

    // ------------------------------------------------------------------
    // Registered interrupt outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50m or negedge resetn) begin
        if (!resetn) begin
            irq_out <= '0;
            irq_any <= 1'b0;
        end else begin
            irq_out <= pending_q[NUM_IRQ-1:0] & enable_q[NUM_IRQ-1:0];
            irq_any <= |(pending_q & enable_q);
        end
    end

endmodule
